phy_reset_seq: RTL
==================

PHY_RESET_SEQ -- requirements
Module: phy_reset_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1024, cycles phy_rst_n is held low after PLL lock (legal >= 2).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4096, cycles after PHY release before the core leaves reset (legal >= 2).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pll_locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-006 SHALL have port restart  input  1  synchronous single-cycle request to re-run the PHY reset sequence.
REQ-007 SHALL have port phy_rst_n  output  1  active-low hardware reset to the external Ethernet PHY, registered.
REQ-008 SHALL have port core_sreset  output  1  active-high synchronous reset to downstream MAC/stream logic, registered.
REQ-009 SHALL have port ready  output  1  high only while the sequence has completed and the link logic may run, registered.

Function
REQ-010 SHALL pass pll_locked through a two-flop synchronizer; lock_s (second-flop output) drives all decisions.
REQ-011 SHALL implement states WAIT_LOCK, HOLD, SETTLE and RUN.
REQ-012 In WAIT_LOCK: phy_rst_n=0, core_sreset=1, ready=0; on lock_s=1, next state HOLD with the counter cleared.
REQ-013 In HOLD: phy_rst_n=0, core_sreset=1, ready=0; remain exactly HOLD_CYCLES cycles, then SETTLE with the counter cleared.
REQ-014 In SETTLE: phy_rst_n=1, core_sreset=1, ready=0; remain exactly SETTLE_CYCLES cycles, then RUN.
REQ-015 In RUN: phy_rst_n=1, core_sreset=0, ready=1; hold indefinitely until lock loss or restart.
REQ-016 Outputs SHALL be registered and change on the same clk edge as the state that defines them.
REQ-017 lock_s=0 in HOLD, SETTLE or RUN SHALL force WAIT_LOCK on the next edge.
REQ-018 restart=1 in SETTLE or RUN SHALL force HOLD with the counter cleared on the next edge.
REQ-019 restart=1 in HOLD SHALL clear the counter, so HOLD lasts a full HOLD_CYCLES from the last restart.
REQ-020 restart SHALL be ignored in WAIT_LOCK.
REQ-021 If lock loss and restart coincide, lock loss SHALL take priority (next state WAIT_LOCK).
REQ-022 There SHALL be one shared counter of width $clog2(max(HOLD_CYCLES, SETTLE_CYCLES)). It SHALL never wrap, because terminal-count compares end each state.

Reset
REQ-023 aresetn=0 SHALL asynchronously force state=WAIT_LOCK, counter=0, both synchronizer flops=0, phy_rst_n=0, core_sreset=1 and ready=0.
REQ-024 aresetn asserted mid-sequence, in any state, SHALL produce the REQ-023 values immediately, without waiting for clk.
REQ-025 After aresetn deasserts, the sequence SHALL restart from WAIT_LOCK; outputs SHALL hold reset values until lock_s=1.

Structure
REQ-026 The state enum SHALL live in shared package eth_reset_pkg, as phy_rst_state_t.
REQ-027 The synchronizer SHALL be the sub-module sync_2ff (1-bit, clk/aresetn, reset value 0), reusable elsewhere.
REQ-028 No other sub-modules SHALL be used; the FSM and counter SHALL live in phy_reset_seq.

Verification (HOLD_CYCLES=4, SETTLE_CYCLES=6)
REQ-029 Nominal sequence: release aresetn, raise pll_locked at cycle 0 -> HOLD entered at edge 3; phy_rst_n rises at edge 7; core_sreset falls and ready rises at edge 13.
REQ-030 Lock loss: drop pll_locked in RUN -> phy_rst_n=0, core_sreset=1 and ready=0 within 3 edges. Re-lock -> full 4+6 sequence repeats.
REQ-031 Restart in RUN: pulse restart for one cycle -> next edge phy_rst_n=0 and ready=0; phy_rst_n low exactly 4 cycles, then 6 cycles of SETTLE.
REQ-032 Restart in HOLD: pulse restart at HOLD cycle 2 -> HOLD extends to exactly 4 cycles after the pulse; total phy_rst_n low time grows by 3 cycles.
REQ-033 Collision and async reset: restart and lock loss on the same cycle -> WAIT_LOCK. aresetn pulsed low mid-SETTLE, between edges -> outputs return to reset values before the next edge.
REQ-034 Glitch check: a 1-cycle pll_locked glitch during WAIT_LOCK -> HOLD entered, then WAIT_LOCK once lock_s falls; phy_rst_n never deasserts.

Source files
------------

// File: rtl/eth_reset_pkg.sv
// Shared types and helpers for the Ethernet PHY reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package eth_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } phy_rst_state_t;

  // Registered reset outputs travel together so they always switch on one edge
  typedef struct packed {
    logic phy_rst_n;
    logic core_sreset;
    logic ready;
  } rst_outs_t;

  localparam rst_outs_t OUTS_RESET = '{phy_rst_n: 1'b0, core_sreset: 1'b1, ready: 1'b0};

  // Output decode for each state
  function automatic rst_outs_t outs_for(input phy_rst_state_t s);
    rst_outs_t o;
    o = OUTS_RESET;
    case (s)
      SETTLE:  o = '{phy_rst_n: 1'b1, core_sreset: 1'b1, ready: 1'b0};
      RUN:     o = '{phy_rst_n: 1'b1, core_sreset: 1'b0, ready: 1'b1};
      default: o = OUTS_RESET;
    endcase
    return o;
  endfunction

  // Counter width large enough for the longer of the two timed phases
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk edges from d to q.
// Backpressure: none; level signal, no handshake.
module sync_2ff (
  input  logic clk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both clear to 0 on reset
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/phy_reset_seq.sv
// Sequences PHY hardware reset and core sync reset after PLL lock.
// Latency: HOLD entered 3 edges after pll_locked rises; RUN after HOLD_CYCLES+SETTLE_CYCLES more.
// Backpressure: none; lock loss or restart re-enters the sequence on the next decision edge.
module phy_reset_seq
  import eth_reset_pkg::*;
#(
  parameter int HOLD_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic clk,
  input  logic aresetn,
  input  logic pll_locked,
  input  logic restart,
  output logic phy_rst_n,
  output logic core_sreset,
  output logic ready
);

  localparam int CW = cnt_width(HOLD_CYCLES, SETTLE_CYCLES);
  // Terminal counts: each timed state ends on its last count, so the counter never wraps
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  phy_rst_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  rst_outs_t      outs_q, outs_nxt;
  logic           lock_s;

  sync_2ff u_lock_sync (
    .clk     (clk),
    .aresetn (aresetn),
    .d       (pll_locked),
    .q       (lock_s)
  );

  // State, shared counter and registered outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= WAIT_LOCK;
      cnt    <= '0;
      outs_q <= OUTS_RESET;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      outs_q <= outs_nxt;
    end
  end

  // Next state / counter; lock loss outranks restart, restart outranks terminal count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (restart) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (restart) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (restart) begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
    // Outputs decoded from the next state so they switch with the state register
    outs_nxt = outs_for(state_nxt);
  end

  assign phy_rst_n   = outs_q.phy_rst_n;
  assign core_sreset = outs_q.core_sreset;
  assign ready       = outs_q.ready;

endmodule
